// File: rtl/poly_mult_dummy_sched.sv
// Sequencer between the CW305 register block and the poly_mult core.
// Hides one real multiplication among LFSR-driven dummies with slot-independent run timing.
module poly_mult_dummy_sched #(
    parameter int unsigned       KEY_W        = 256,
    parameter int unsigned       DATA_W       = 128,
    parameter int unsigned       SLOT_W       = 3,
    parameter int unsigned       LFSR_W       = 32,
    parameter logic [LFSR_W-1:0] LFSR_SEED    = 32'hACE1_2468,
    parameter int unsigned       BUSY_TIMEOUT = 4,
    parameter bit                TRIG_REAL    = 1'b1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start_i,
    input  logic [KEY_W-1:0]  key_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [SLOT_W-1:0] dummy_cnt_i,
    input  logic [LFSR_W-1:0] seed_i,
    input  logic              seed_load_i,
    output logic              pm_load_o,
    output logic [KEY_W-1:0]  pm_key_o,
    output logic [DATA_W-1:0] pm_data_o,
    input  logic              pm_busy_i,
    input  logic [DATA_W-1:0] pm_result_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] result_o,
    output logic              trigger_o,
    output logic              err_o
);

    localparam int unsigned       KEY_REP   = KEY_W / LFSR_W;
    localparam int unsigned       DATA_REP  = DATA_W / LFSR_W;
    localparam int unsigned       CNT_W     = SLOT_W + 1;
    localparam int unsigned       WAIT_W    = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(BUSY_TIMEOUT - 1);
    localparam logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(32'h8020_0003);

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StLoad,
        StWaitBusy,
        StRun,
        StCapture,
        StFin
    } state_e;

    state_e            state_q;
    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;
    logic [LFSR_W-1:0] lfsr_step;
    logic [KEY_W-1:0]  key_q;
    logic [DATA_W-1:0] data_q;
    logic [CNT_W-1:0]  total_q;
    logic [CNT_W-1:0]  idx_q;
    logic [CNT_W-1:0]  slot_q;
    logic [CNT_W-1:0]  idx_red;
    logic [CNT_W-1:0]  slot_nxt;
    logic [SLOT_W-1:0] arm_cnt_q;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic              last_slot;
    logic              load_real;
    logic              enter_load;
    logic [KEY_W-1:0]  dummy_key;
    logic [DATA_W-1:0] dummy_data;

    // Galois right-shift form of x^32+x^22+x^2+x+1
    assign lfsr_step = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);

    always_comb begin
        lfsr_d = lfsr_step;
        if (state_q == StIdle && seed_load_i) begin
            lfsr_d = (seed_i == '0) ? LFSR_SEED : seed_i;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // One conditional subtract per ARM cycle; 2^SLOT_W cycles always suffice for the modulo.
    assign idx_red    = (idx_q >= total_q) ? idx_q - total_q : idx_q;
    assign slot_nxt   = slot_q + CNT_W'(1);
    assign last_slot  = (slot_nxt == total_q);
    assign load_real  = (state_q == StArm) ? (idx_red == '0) : (slot_nxt == idx_q);
    assign enter_load = (state_q == StArm && arm_cnt_q == '1) ||
                        (state_q == StCapture && !last_slot);

    // lfsr_d is what lfsr_q holds during LOAD, so dummies reflect the LOAD-cycle LFSR state.
    assign dummy_key  = {KEY_REP{lfsr_d}};
    assign dummy_data = {DATA_REP{lfsr_d}};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            key_q      <= '0;
            data_q     <= '0;
            total_q    <= '0;
            idx_q      <= '0;
            slot_q     <= '0;
            arm_cnt_q  <= '0;
            wait_cnt_q <= '0;
            pm_load_o  <= 1'b0;
            pm_key_o   <= '0;
            pm_data_o  <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            result_o   <= '0;
            trigger_o  <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            pm_load_o <= 1'b0;
            done_o    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        key_q     <= key_i;
                        data_q    <= data_i;
                        total_q   <= {1'b0, dummy_cnt_i} + CNT_W'(1);
                        idx_q     <= {1'b0, lfsr_q[SLOT_W-1:0]};
                        slot_q    <= '0;
                        arm_cnt_q <= '0;
                        busy_o    <= 1'b1;
                        err_o     <= 1'b0;
                        trigger_o <= !TRIG_REAL;
                        state_q   <= StArm;
                    end
                end
                StArm: begin
                    idx_q     <= idx_red;
                    arm_cnt_q <= arm_cnt_q + SLOT_W'(1);
                    if (arm_cnt_q == '1) begin
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    wait_cnt_q <= '0;
                    state_q    <= StWaitBusy;
                end
                StWaitBusy: begin
                    if (pm_busy_i) begin
                        state_q <= StRun;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        err_o     <= 1'b1;
                        done_o    <= 1'b1;
                        trigger_o <= !TRIG_REAL;
                        state_q   <= StFin;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                    end
                end
                StRun: begin
                    if (!pm_busy_i) begin
                        state_q <= StCapture;
                    end
                end
                StCapture: begin
                    if (slot_q == idx_q) begin
                        result_o <= pm_result_i;
                    end
                    slot_q <= slot_nxt;
                    if (last_slot) begin
                        done_o    <= 1'b1;
                        trigger_o <= !TRIG_REAL;
                        state_q   <= StFin;
                    end else begin
                        state_q <= StLoad;
                    end
                end
                StFin: begin
                    busy_o    <= 1'b0;
                    trigger_o <= 1'b0;
                    state_q   <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase

            if (enter_load) begin
                pm_load_o <= 1'b1;
                pm_key_o  <= load_real ? key_q : dummy_key;
                pm_data_o <= load_real ? data_q : dummy_data;
                trigger_o <= TRIG_REAL ? load_real : 1'b1;
            end
        end
    end

endmodule
